// File: rtl/i2s_receiver.sv
// I2S serial-to-parallel receiver.
// Samples SerialData on rising SCK, framed by WS, and presents one {left,right}
// frame on a valid/ready handshake.
// Optional build macro: I2S_RX_OVERRUN_EN adds a sticky Overrun flag and makes an
// unaccepted frame win over a newer one (the newer frame is dropped).
module i2s_receiver #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned WS_DELAY = 1
) (
    input  logic               SCK,
    input  logic               nreset,
    input  logic               WS,
    input  logic               SerialData,
    input  logic               DataReady,
    output logic [2*WIDTH-1:0] FrameData,
    output logic               DataValid
`ifdef I2S_RX_OVERRUN_EN
    ,
    output logic               Overrun
`endif
);

    localparam int unsigned      CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MSB_ONE = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {StSync, StLeft, StRight} state_e;

    state_e           state_q;
    logic             ws_q;
    logic             ws_prev;
    logic             ws_eff;
    logic [WIDTH-1:0] left_sr;
    logic [WIDTH-1:0] right_sr;
    logic [CW-1:0]    cnt_q;

    logic             start_edge;
    logic             left_start;
    logic             right_start;
    logic             frame_done;
    logic             overrun_case;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] msb_word;

    // Philips mode looks at WS one SCK late so the MSB lands on the start edge.
    assign ws_eff      = (WS_DELAY != 0) ? ws_q : WS;
    assign start_edge  = (ws_eff != ws_prev);
    assign left_start  = start_edge & ~ws_eff;
    assign right_start = start_edge & ws_eff;

    // Mask walks right one bit per SCK and becomes zero once WIDTH bits are in,
    // which discards surplus bits and leaves short words zero-padded.
    assign bit_mask = MSB_ONE >> cnt_q;
    assign msb_word = SerialData ? MSB_ONE : '0;

    assign frame_done   = (state_q == StRight) && left_start;
    assign overrun_case = frame_done && DataValid && !DataReady;

    // WS delay line and previous effective WS for start-edge detection.
    always_ff @(posedge SCK or negedge nreset) begin
        if (!nreset) begin
            ws_q    <= 1'b0;
            ws_prev <= 1'b0;
        end else begin
            ws_q    <= WS;
            ws_prev <= ws_eff;
        end
    end

    // Channel FSM, word assembly and output handshake.
    always_ff @(posedge SCK or negedge nreset) begin
        if (!nreset) begin
            state_q   <= StSync;
            left_sr   <= '0;
            right_sr  <= '0;
            cnt_q     <= '0;
            FrameData <= '0;
            DataValid <= 1'b0;
`ifdef I2S_RX_OVERRUN_EN
            Overrun   <= 1'b0;
`endif
        end else begin
            if (left_start) begin
                state_q <= StLeft;
                left_sr <= msb_word;
                cnt_q   <= CW'(1);
            end else if (right_start && (state_q != StSync)) begin
                state_q  <= StRight;
                right_sr <= msb_word;
                cnt_q    <= CW'(1);
            end else if (state_q != StSync) begin
                if (cnt_q != WIDTH_C) begin
                    cnt_q <= cnt_q + CW'(1);
                end
                if (state_q == StLeft) begin
                    left_sr <= SerialData ? (left_sr | bit_mask) : (left_sr & ~bit_mask);
                end else begin
                    right_sr <= SerialData ? (right_sr | bit_mask) : (right_sr & ~bit_mask);
                end
            end

            // Right word is already complete: its LSB arrived on the previous edge.
            if (frame_done) begin
                if (overrun_case) begin
`ifdef I2S_RX_OVERRUN_EN
                    Overrun <= 1'b1;
`else
                    FrameData <= {left_sr, right_sr};
`endif
                end else begin
                    FrameData <= {left_sr, right_sr};
                    DataValid <= 1'b1;
                end
            end else if (DataValid && DataReady) begin
                DataValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: one instance in Philips alignment (WS_DELAY=1)
// and one with MSB aligned to the WS change (WS_DELAY=0), fed the same logical
// bit stream. The delayed instance therefore completes frames one SCK later.
module tb_i2s_receiver;

    logic        SCK;
    logic        nreset;
    logic        ws0, sd0, rdy0;
    logic        ws1, sd1, rdy1;
    logic [15:0] fd0, fd1;
    logic        dv0, dv1;
`ifdef I2S_RX_OVERRUN_EN
    logic        ovr0, ovr1;
    localparam logic [15:0] OVR_FD = 16'h1122;
`else
    localparam logic [15:0] OVR_FD = 16'h3344;
`endif

    int   total;
    int   bad;
    logic pend;

    i2s_receiver #(.WIDTH(8), .WS_DELAY(0)) dut0 (
        .SCK        (SCK),
        .nreset     (nreset),
        .WS         (ws0),
        .SerialData (sd0),
        .DataReady  (rdy0),
        .FrameData  (fd0),
        .DataValid  (dv0)
`ifdef I2S_RX_OVERRUN_EN
        ,
        .Overrun    (ovr0)
`endif
    );

    i2s_receiver #(.WIDTH(8), .WS_DELAY(1)) dut1 (
        .SCK        (SCK),
        .nreset     (nreset),
        .WS         (ws1),
        .SerialData (sd1),
        .DataReady  (rdy1),
        .FrameData  (fd1),
        .DataValid  (dv1)
`ifdef I2S_RX_OVERRUN_EN
        ,
        .Overrun    (ovr1)
`endif
    );

    initial begin
        SCK = 1'b0;
        forever #5 SCK = ~SCK;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bit time: dut0 gets WS with its bit, dut1 gets WS one SCK ahead of its bit.
    task automatic send(input logic ch, input logic d);
        @(negedge SCK);
        ws0  = ch;
        sd0  = d;
        ws1  = ch;
        sd1  = pend;
        pend = d;
        @(posedge SCK);
        #1;
    endtask

    task automatic send_word(input logic ch, input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send(ch, w[i]);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        pend   = 1'b0;
        nreset = 1'b0;
        ws0 = 1'b1; sd0 = 1'b0; rdy0 = 1'b0;
        ws1 = 1'b1; sd1 = 1'b0; rdy1 = 1'b0;
        repeat (3) @(posedge SCK);
        #1;
        chk("rst_fd1", fd1, 16'h0000);
        chk("rst_dv1", {15'd0, dv1}, 16'd0);
        chk("rst_dv0", {15'd0, dv0}, 16'd0);
`ifdef I2S_RX_OVERRUN_EN
        chk("rst_ovr1", {15'd0, ovr1}, 16'd0);
`endif
        @(negedge SCK);
        nreset = 1'b1;

        // Partial right slot, then first full frame A5/3C: no output yet.
        send_word(1'b1, 16'h000F, 4);
        send_word(1'b0, 16'h00A5, 8);
        send_word(1'b1, 16'h003C, 8);
        chk("first_frame_dv0", {15'd0, dv0}, 16'd0);
        chk("first_frame_dv1", {15'd0, dv1}, 16'd0);

        // Second left start: dut0 completes now, dut1 one SCK later.
        send(1'b0, 1'b1);
        chk("a53c_dv0", {15'd0, dv0}, 16'd1);
        chk("a53c_fd0", fd0, 16'hA53C);
        chk("a53c_dv1_early", {15'd0, dv1}, 16'd0);
        send(1'b0, 1'b1);
        chk("a53c_dv1", {15'd0, dv1}, 16'd1);
        chk("a53c_fd1", fd1, 16'hA53C);

        // One-edge accept on both.
        rdy0 = 1'b1; rdy1 = 1'b1;
        send(1'b0, 1'b0);
        rdy0 = 1'b0; rdy1 = 1'b0;
        chk("accept_dv0", {15'd0, dv0}, 16'd0);
        chk("accept_dv1", {15'd0, dv1}, 16'd0);

        // Left slot 10 bits 1100110011 (first 3 already sent), right slot 6 bits 101101.
        send_word(1'b0, 16'b0110011, 7);
        send_word(1'b1, 16'b101101, 6);
        send(1'b0, 1'b0);
        chk("ccb4_fd0", fd0, 16'hCCB4);
        chk("ccb4_dv0", {15'd0, dv0}, 16'd1);
        send(1'b0, 1'b0);
        chk("ccb4_fd1", fd1, 16'hCCB4);
        chk("ccb4_dv1", {15'd0, dv1}, 16'd1);
        rdy0 = 1'b1; rdy1 = 1'b1;
        send(1'b0, 1'b0);
        rdy0 = 1'b0; rdy1 = 1'b0;
        chk("ccb4_clr_dv0", {15'd0, dv0}, 16'd0);
        chk("ccb4_clr_dv1", {15'd0, dv1}, 16'd0);

        // Frames 0x1122 then 0x3344 with DataReady held low.
        send_word(1'b0, 16'b10001, 5);
        send_word(1'b1, 16'h0022, 8);
        send_word(1'b0, 16'h0033, 8);
        send_word(1'b1, 16'h0044, 8);
        chk("f1122_fd0", fd0, 16'h1122);
        chk("f1122_fd1", fd1, 16'h1122);
        chk("f1122_dv1", {15'd0, dv1}, 16'd1);

        // dut0: completion while still holding an unaccepted frame.
        send(1'b0, 1'b0);
        chk("ovr_fd0", fd0, OVR_FD);
        chk("ovr_dv0", {15'd0, dv0}, 16'd1);
`ifdef I2S_RX_OVERRUN_EN
        chk("ovr_flag0", {15'd0, ovr0}, 16'd1);
`endif

        // dut1: accept on the very edge the next frame completes.
        rdy1 = 1'b1;
        send(1'b0, 1'b1);
        rdy1 = 1'b0;
        chk("simul_fd1", fd1, 16'h3344);
        chk("simul_dv1", {15'd0, dv1}, 16'd1);
`ifdef I2S_RX_OVERRUN_EN
        chk("simul_ovr1", {15'd0, ovr1}, 16'd0);
`endif

        // Reset pulsed mid right slot.
        send_word(1'b0, 16'b011010, 6);
        send_word(1'b1, 16'b1100, 4);
        #2;
        nreset = 1'b0;
        #1;
        chk("mid_rst_fd0", fd0, 16'h0000);
        chk("mid_rst_dv0", {15'd0, dv0}, 16'd0);
        chk("mid_rst_fd1", fd1, 16'h0000);
        chk("mid_rst_dv1", {15'd0, dv1}, 16'd0);
`ifdef I2S_RX_OVERRUN_EN
        chk("mid_rst_ovr0", {15'd0, ovr0}, 16'd0);
`endif
        @(negedge SCK);
        nreset = 1'b1;

        // Rest of the interrupted slot is ignored; next frame needs a full L+R.
        send_word(1'b1, 16'b0011, 4);
        send_word(1'b0, 16'h0077, 8);
        send_word(1'b1, 16'h0088, 8);
        chk("post_rst_dv0", {15'd0, dv0}, 16'd0);
        chk("post_rst_dv1", {15'd0, dv1}, 16'd0);
        send(1'b0, 1'b1);
        chk("f7788_fd0", fd0, 16'h7788);
        chk("f7788_dv0", {15'd0, dv0}, 16'd1);
        send(1'b0, 1'b0);
        chk("f7788_fd1", fd1, 16'h7788);
        chk("f7788_dv1", {15'd0, dv1}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
